// File: rtl/mod_6_down_counter.sv
// Mod-6 down counter (0,5,4,3,2,1,0...) with parallel load and borrow out.
// State lives in three d_ff cells; next-state logic is plain gates.

module d_ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) q <= 1'b0;
      else     q <= d;
   end

endmodule

module mod_6_down_counter (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       ld,
   input  logic [2:0] din,
   output logic [2:0] count,
   output logic       zero,
   output logic       bo
);

   logic       illegal;
   logic [2:0] dec;
   logic [2:0] load;
   logic [2:0] nxt;

   assign zero    = ~count[2] & ~count[1] & ~count[0];
   assign illegal = count[2] & count[1];
   assign bo      = en & zero & ~rst;

   // count-1 over 1..5, with 0 wrapping to 5
   assign dec[0] = ~count[0];
   assign dec[1] = (count[1] & count[0]) | (count[2] & ~count[0]);
   assign dec[2] = zero | (count[2] & count[0]);

   // din of 6 or 7 saturates to 5
   assign load[2] = din[2];
   assign load[1] = din[1] & ~din[2];
   assign load[0] = din[0] | (din[2] & din[1]);

   // priority: ld > illegal-state recovery > en > hold
   assign nxt[2] = (ld & load[2])
                 | (~ld & illegal)
                 | (~ld & ~illegal & en & dec[2])
                 | (~ld & ~illegal & ~en & count[2]);
   assign nxt[1] = (ld & load[1])
                 | (~ld & ~illegal & en & dec[1])
                 | (~ld & ~illegal & ~en & count[1]);
   assign nxt[0] = (ld & load[0])
                 | (~ld & illegal)
                 | (~ld & ~illegal & en & dec[0])
                 | (~ld & ~illegal & ~en & count[0]);

   d_ff u_b0 (.clk(clk), .rst(rst), .d(nxt[0]), .q(count[0]));
   d_ff u_b1 (.clk(clk), .rst(rst), .d(nxt[1]), .q(count[1]));
   d_ff u_b2 (.clk(clk), .rst(rst), .d(nxt[2]), .q(count[2]));

endmodule

// File: tb/tb_mod_6_down_counter.sv
// Directed vector bench for mod_6_down_counter.
// Each vector: inputs, borrow expected before the edge, count after it.

module tb_mod_6_down_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic       ld  = 1'b0;
   logic [2:0] din = 3'd0;
   logic [2:0] count;
   logic       zero;
   logic       bo;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic       rst;
      logic       ld;
      logic       en;
      logic [2:0] din;
      logic       pre_bo;
      logic [2:0] post_count;
   } vec_t;

   vec_t tbl[$];

   mod_6_down_counter dut (
      .clk(clk), .rst(rst), .en(en), .ld(ld),
      .din(din), .count(count), .zero(zero), .bo(bo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic r, input logic l, input logic e,
                      input logic [2:0] d, input logic b, input logic [2:0] c);
      vec_t v;
      v.rst = r; v.ld = l; v.en = e; v.din = d;
      v.pre_bo = b; v.post_count = c;
      tbl.push_back(v);
   endtask

   task automatic apply(input vec_t v, input int idx);
      @(negedge clk);
      rst = v.rst; ld = v.ld; en = v.en; din = v.din;
      #1;
      check($sformatf("v%0d bo", idx), int'(bo), int'(v.pre_bo));
      @(posedge clk);
      #1;
      check($sformatf("v%0d count", idx), int'(count), int'(v.post_count));
      check($sformatf("v%0d zero", idx), int'(zero),
            int'(v.post_count == 3'd0));
   endtask

   initial begin
      // reset held for 3 edges with en=1
      add(1, 0, 1, 0, 0, 0);
      add(1, 0, 1, 0, 0, 0);
      add(1, 0, 1, 0, 0, 0);
      // full countdown, 12 edges
      add(0, 0, 1, 0, 1, 5);
      add(0, 0, 1, 0, 0, 4);
      add(0, 0, 1, 0, 0, 3);
      add(0, 0, 1, 0, 0, 2);
      add(0, 0, 1, 0, 0, 1);
      add(0, 0, 1, 0, 0, 0);
      add(0, 0, 1, 0, 1, 5);
      add(0, 0, 1, 0, 0, 4);
      add(0, 0, 1, 0, 0, 3);
      add(0, 0, 1, 0, 0, 2);
      add(0, 0, 1, 0, 0, 1);
      add(0, 0, 1, 0, 0, 0);
      // reach 3, then hold
      add(0, 0, 1, 0, 1, 5);
      add(0, 0, 1, 0, 0, 4);
      add(0, 0, 1, 0, 0, 3);
      add(0, 0, 0, 0, 0, 3);
      add(0, 0, 0, 0, 0, 3);
      add(0, 0, 0, 0, 0, 3);
      add(0, 0, 0, 0, 0, 3);
      add(0, 0, 1, 0, 0, 2);
      add(0, 0, 1, 0, 0, 1);
      // load beats enable
      add(0, 1, 1, 4, 0, 4);
      add(0, 0, 1, 0, 0, 3);
      // illegal load values saturate
      add(0, 1, 0, 7, 0, 5);
      add(0, 1, 0, 6, 0, 5);
      add(0, 1, 1, 0, 0, 0);
      // load at zero with en: borrow still reflects pre-edge state
      add(0, 1, 1, 3, 1, 3);
      add(0, 1, 0, 5, 0, 5);
      add(0, 0, 1, 0, 0, 4);

      #2;
      check("reset count", int'(count), 0);
      check("reset zero", int'(zero), 1);
      check("reset bo", int'(bo), 0);

      foreach (tbl[i]) apply(tbl[i], i);

      // async reset mid-count: reach 2 via en edge, then rst 0.3 cycle later
      begin
         vec_t v;
         v.rst = 0; v.ld = 1; v.en = 0; v.din = 3;
         v.pre_bo = 0; v.post_count = 3;
         apply(v, 100);
         v.ld = 0; v.en = 1; v.din = 0; v.post_count = 2;
         apply(v, 101);
      end
      #2;
      rst = 1'b1;
      #1;
      check("async rst count", int'(count), 0);
      check("async rst zero", int'(zero), 1);
      check("async rst bo", int'(bo), 0);
      @(negedge clk);
      rst = 1'b0; en = 1'b1; ld = 1'b0;
      #1;
      check("post rst bo", int'(bo), 1);
      @(posedge clk);
      #1;
      check("post rst count", int'(count), 5);
      check("post rst bo low", int'(bo), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
